switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//  Upstream partner of the one-cycle pulser. Takes a raw asynchronous switch or
//  button level and synchronises it to clock. It produces a clean debounced
//  level (dataOut), plus one-cycle rise/fall strobes.
//  Sits between board pins and the pulser / control FSMs.
// PARAMETERS
//  STABLE_CYCLES  50000  consecutive synced samples beyond the first needed to accept a new level (>=1)
//  CNT_WIDTH      16     stability counter width; 2**CNT_WIDTH must be >= STABLE_CYCLES
// PORTS
//  clock     in   1  system clock, rising edge
//  reset     in   1  asynchronous, active-high
//  dataIn    in   1  raw, bouncing, asynchronous input level
//  dataOut   out  1  debounced level, registered
//  riseOut   out  1  one-cycle strobe, high in the first cycle dataOut is 1
//  fallOut   out  1  one-cycle strobe, high in the first cycle dataOut is 0 after being 1
// BEHAVIOUR
//  Reset (async, asserted): sync1=sync2=0, state=LOW, count=0, dataOut=riseOut=fallOut=0.
//   Held in this condition while reset is high, regardless of dataIn.
//  Synchroniser: two flops, sync1<=dataIn, sync2<=sync1; synced=sync2. No logic between them.
//  FSM (2-bit): LOW=00, WAIT_HIGH=01, HIGH=10, WAIT_LOW=11. Illegal/default -> LOW.
//   LOW:       synced=1 -> WAIT_HIGH, count<=0; else stay.
//   WAIT_HIGH: synced=0 -> LOW, count<=0.
//              synced=1 and count==STABLE_CYCLES-1 -> HIGH.
//              synced=1 otherwise -> stay, count<=count+1.
//   HIGH:      synced=0 -> WAIT_LOW, count<=0; else stay.
//   WAIT_LOW:  synced=1 -> HIGH, count<=0.
//              synced=0 and count==STABLE_CYCLES-1 -> LOW.
//              synced=0 otherwise -> stay, count<=count+1.
//  Outputs are registered alongside state:
//   dataOut=1 exactly while state is HIGH or WAIT_LOW.
//   riseOut=1 for the single cycle after the WAIT_HIGH->HIGH transition.
//   fallOut=1 for the single cycle after the WAIT_LOW->LOW transition.
//   riseOut and fallOut are never high together. An aborted wait produces no strobe.
//  Acceptance rule: a new level is accepted only if dataIn holds it for
//   STABLE_CYCLES+1 consecutive sampling edges. A run of <=STABLE_CYCLES is rejected.
//   A rejected run leaves dataOut unchanged.
//  Latency: dataIn changes before edge 1 and stays stable. dataOut, with the matching
//   strobe, changes after edge STABLE_CYCLES+3.
//  Counter never wraps: it is bounded by the compare at STABLE_CYCLES-1.
//   It is cleared on every WAIT abort and on every WAIT entry.
//  Any bounce during a WAIT restarts qualification from zero.
//   The new wait begins at the next opposite-level sample.
//  Reset mid-WAIT or in HIGH: all outputs drop to 0 asynchronously; no strobe is produced.
//   After release, if dataIn is high, full requalification is required.
// TESTING (bench uses STABLE_CYCLES=4)
//  1 Assert reset with dataIn=1 for 10 cycles -> dataOut/riseOut/fallOut stay 0.
//    State stays LOW.
//  2 Release reset, dataIn 0->1 before edge 1, held -> dataOut=1 and riseOut=1 after edge 7.
//    riseOut=0 after edge 8; fallOut stays 0 throughout.
//  3 dataIn high for exactly 4 edges, then 0 -> dataOut never rises, no strobes.
//    Repeat with 5 edges -> dataOut rises, riseOut pulses once.
//  4 From LOW, apply dataIn pattern 1,0,1,1,0,1,1,1,1,1, then hold 1 -> exactly one riseOut.
//    dataOut rises 7 edges after the start of the final 1-run.
//  5 From HIGH, dataIn 1->0 held -> dataOut=0 and fallOut=1 after edge 7 (1 cycle).
//    A 4-edge low glitch from HIGH -> dataOut stays 1.
//  6 Assert reset while in WAIT_HIGH (count=2), then release with dataIn=1 held.
//    -> Outputs 0 during reset; dataOut rises 7 edges after release, single riseOut.

Source files
------------

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus a four-state qualification FSM that turns a
// bouncing switch level into a clean level with one-cycle rise/fall strobes.
//
// Ports:
//   clock    in  system clock, rising edge
//   reset    in  asynchronous, active-high
//   dataIn   in  raw asynchronous switch level
//   dataOut  out debounced level, registered
//   riseOut  out one-cycle strobe on the first cycle dataOut is 1
//   fallOut  out one-cycle strobe on the first cycle dataOut is 0 after 1
module switch_debouncer #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic dataIn,
    output logic dataOut,
    output logic riseOut,
    output logic fallOut
);

    typedef enum logic [1:0] {
        LOW       = 2'b00,
        WAIT_HIGH = 2'b01,
        HIGH      = 2'b10,
        WAIT_LOW  = 2'b11
    } state_t;

    // Count value reached after STABLE_CYCLES samples past the wait entry.
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 sync1;
    logic                 sync2;
    logic                 synced;
    state_t               state;
    state_t               next_state;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] next_count;
    logic                 data_next;
    logic                 rise_next;
    logic                 fall_next;

    assign synced = sync2;

    // Synchroniser: plain flop chain, nothing in between.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= dataIn;
            sync2 <= sync1;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= LOW;
            count   <= '0;
            dataOut <= 1'b0;
            riseOut <= 1'b0;
            fallOut <= 1'b0;
        end else begin
            state   <= next_state;
            count   <= next_count;
            dataOut <= data_next;
            riseOut <= rise_next;
            fallOut <= fall_next;
        end
    end

    // Next state and counter.
    always_comb begin
        next_state = state;
        next_count = count;
        case (state)
            LOW: begin
                if (synced) begin
                    next_state = WAIT_HIGH;
                    next_count = '0;
                end
            end
            WAIT_HIGH: begin
                if (!synced) begin
                    next_state = LOW;
                    next_count = '0;
                end else if (count == LAST) begin
                    next_state = HIGH;
                end else begin
                    next_count = count + CNT_WIDTH'(1);
                end
            end
            HIGH: begin
                if (!synced) begin
                    next_state = WAIT_LOW;
                    next_count = '0;
                end
            end
            WAIT_LOW: begin
                if (synced) begin
                    next_state = HIGH;
                    next_count = '0;
                end else if (count == LAST) begin
                    next_state = LOW;
                end else begin
                    next_count = count + CNT_WIDTH'(1);
                end
            end
            default: begin
                next_state = LOW;
                next_count = '0;
            end
        endcase
    end

    // Output values loaded together with the next state, so the strobes
    // land in the first cycle the new level is visible.
    always_comb begin
        data_next = (next_state == HIGH) || (next_state == WAIT_LOW);
        rise_next = (state == WAIT_HIGH) && (next_state == HIGH);
        fall_next = (state == WAIT_LOW) && (next_state == LOW);
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Testbench for switch_debouncer: directed scenarios plus random bouncing,
// checked cycle by cycle against a run-length reference model.
module tb_switch_debouncer;

    localparam int S = 4;

    logic clock;
    logic reset;
    logic dataIn;
    logic dataOut;
    logic riseOut;
    logic fallOut;

    int checks;
    int fails;
    int rise_cnt;
    int fall_cnt;

    logic [2:0] sb[$];

    // Model state: sampled history and run length of the opposite level.
    logic m_s1;
    logic m_s2;
    logic m_level;
    int   m_run;

    switch_debouncer #(
        .STABLE_CYCLES(S),
        .CNT_WIDTH(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .dataIn(dataIn),
        .dataOut(dataOut),
        .riseOut(riseOut),
        .fallOut(fallOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a level is adopted once the synced input has shown
    // the opposite value for S+1 consecutive samples; any match resets the run.
    initial begin
        logic v;
        logic r;
        logic f;
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        m_level = 1'b0;
        m_run = 0;
        forever begin
            @(posedge clock);
            r = 1'b0;
            f = 1'b0;
            if (reset) begin
                m_s1 = 1'b0;
                m_s2 = 1'b0;
                m_level = 1'b0;
                m_run = 0;
            end else begin
                v = m_s2;
                if (v != m_level) begin
                    m_run++;
                    if (m_run == S + 1) begin
                        m_level = v;
                        m_run = 0;
                        r = v;
                        f = !v;
                    end
                end else begin
                    m_run = 0;
                end
                m_s2 = m_s1;
                m_s1 = dataIn;
            end
            sb.push_back({m_level, r, f});
        end
    end

    // Monitor: one expected triple per edge, compared on the falling edge.
    initial begin
        logic [2:0] e;
        rise_cnt = 0;
        fall_cnt = 0;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("dataOut", int'(dataOut), int'(e[2]));
                check("riseOut", int'(riseOut), int'(e[1]));
                check("fallOut", int'(fallOut), int'(e[0]));
                if (riseOut) rise_cnt++;
                if (fallOut) fall_cnt++;
            end
        end
    end

    // One sampling edge with the given input; returns after the monitor.
    task automatic cyc(input logic v);
        dataIn = v;
        @(posedge clock);
        @(negedge clock);
        #2;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) cyc(v);
    endtask

    initial begin
        int r0;
        int f0;
        int hit;
        int pat[10];
        checks = 0;
        fails = 0;
        pat = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

        // 1: reset held with input high
        reset = 1'b1;
        dataIn = 1'b1;
        @(negedge clock);
        #2;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1);
            check("rst_data", int'(dataOut), 0);
        end
        check("rst_rise", rise_cnt, 0);

        // 2: release and qualify a rise; latency S+3 edges
        hold(1'b0, 1);
        reset = 1'b0;
        hold(1'b0, 4);
        r0 = rise_cnt;
        f0 = fall_cnt;
        hold(1'b1, 6);
        check("t2_pre", int'(dataOut), 0);
        cyc(1'b1);
        check("t2_data", int'(dataOut), 1);
        check("t2_rise", int'(riseOut), 1);
        cyc(1'b1);
        check("t2_rise_off", int'(riseOut), 0);
        check("t2_fall", fall_cnt - f0, 0);
        check("t2_nrise", rise_cnt - r0, 1);

        // back to low
        hold(1'b0, 10);
        check("t2_low", int'(dataOut), 0);

        // 3: run of S rejected, S+1 accepted
        r0 = rise_cnt;
        hold(1'b1, 4);
        hold(1'b0, 10);
        check("t3_short", rise_cnt - r0, 0);
        hold(1'b1, 5);
        hold(1'b0, 4);
        check("t3_long", rise_cnt - r0, 1);
        hold(1'b0, 10);

        // 4: bouncing pattern, then steady high
        r0 = rise_cnt;
        hit = -1;
        for (int i = 0; i < 20; i++) begin
            cyc(i < 10 ? pat[i][0] : 1'b1);
            if (hit < 0 && dataOut) hit = i - 4;
        end
        check("t4_lat", hit, 7);
        check("t4_nrise", rise_cnt - r0, 1);

        // 5: fall from high, then a short low glitch
        f0 = fall_cnt;
        hold(1'b0, 6);
        check("t5_pre", int'(dataOut), 1);
        cyc(1'b0);
        check("t5_data", int'(dataOut), 0);
        check("t5_fall", int'(fallOut), 1);
        cyc(1'b0);
        check("t5_fall_off", int'(fallOut), 0);
        hold(1'b1, 10);
        f0 = fall_cnt;
        hold(1'b0, 4);
        hold(1'b1, 10);
        check("t5_glitch", fall_cnt - f0, 0);
        check("t5_hold", int'(dataOut), 1);

        // 6: async reset from HIGH, then reset mid WAIT_HIGH
        reset = 1'b1;
        #1;
        check("t6_async", int'(dataOut), 0);
        hold(1'b0, 2);
        reset = 1'b0;
        hold(1'b0, 3);
        hold(1'b1, 5);
        reset = 1'b1;
        #1;
        check("t6_wait_rst", int'(dataOut), 0);
        r0 = rise_cnt;
        hold(1'b1, 4);
        check("t6_in_rst", int'(dataOut | riseOut | fallOut), 0);
        reset = 1'b0;
        hold(1'b1, 6);
        check("t6_pre", int'(dataOut), 0);
        cyc(1'b1);
        check("t6_data", int'(dataOut), 1);
        check("t6_rise", int'(riseOut), 1);
        hold(1'b1, 3);
        check("t6_nrise", rise_cnt - r0, 1);

        // random bouncing with occasional resets
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                hold(1'($urandom_range(0, 1)), $urandom_range(1, 3));
                reset = 1'b0;
            end
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end

        check("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
